// File: rtl/cmos_stream_gen.sv
// Synthetic OV5640-style camera source: vsync/href/RGB565 stream with programmable timing and test patterns.
// Optional macro CMOS_GEN_FRAME_TAG_EN replaces pixel (0,0) of each frame with the running frame count.
module cmos_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 160,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 8,
    parameter int V_FRONT     = 8
) (
    input  logic        cmos_pclk,
    input  logic        sys_rst,
    input  logic        gen_en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [15:0] cmos_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int L     = H_ACTIVE + H_BLANK;
    localparam int XW    = $clog2(L);
    localparam int M1    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int M2    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int LMAX  = (M1 > M2) ? M1 : M2;
    localparam int LW    = (LMAX < 2) ? 1 : $clog2(LMAX);

    localparam logic [XW-1:0] X_LAST     = XW'(L - 1);
    localparam logic [XW-1:0] X_HREF_END = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_BAR_W    = XW'(H_ACTIVE / 8);
    localparam logic [LW-1:0] VS_LAST    = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] VB_LAST    = LW'(V_BACK - 1);
    localparam logic [LW-1:0] VA_LAST    = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] VF_LAST    = LW'(V_FRONT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [XW-1:0]   x_cnt_r;
    logic [LW-1:0]   line_cnt_r;
    logic [LW-1:0]   line_last_s;
    logic            line_end_s;
    logic            phase_end_s;
    logic            frame_start_s;
    logic            frame_end_s;
    logic            href_s;
    logic [1:0]      pat_r;
    logic [15:0]     solid_r;
    logic [2:0]      bar_idx_s;
    logic [5:0]      x_low_s;
    logic            y_bit5_s;
    logic [15:0]     pat_pix_s;
    logic [15:0]     pix_s;
    logic            vsync_r;
    logic            href_r;
    logic [15:0]     data_r;
    logic            frame_done_r;
    logic [15:0]     frame_cnt_r;

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        logic [15:0] c;
        case (bar)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // Index of the last line of the current state.
    always_comb begin
        line_last_s = {LW{1'b0}};
        case (state_r)
            ST_VSYNC:  line_last_s = VS_LAST;
            ST_VBACK:  line_last_s = VB_LAST;
            ST_ACTIVE: line_last_s = VA_LAST;
            ST_VFRONT: line_last_s = VF_LAST;
            default:   line_last_s = {LW{1'b0}};
        endcase
    end

    assign line_end_s    = (x_cnt_r == X_LAST);
    assign phase_end_s   = line_end_s && (line_cnt_r == line_last_s);
    assign frame_end_s   = (state_r == ST_VFRONT) && phase_end_s;
    assign frame_start_s = (state_next_s == ST_VSYNC) && (state_r != ST_VSYNC);
    assign href_s        = (state_r == ST_ACTIVE) && (x_cnt_r < X_HREF_END);

    // Next-state logic; gen_en only matters in IDLE and on the last clock of VFRONT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gen_en) state_next_s = ST_VSYNC;
                else        state_next_s = ST_IDLE;
            end
            ST_VSYNC: begin
                if (phase_end_s) state_next_s = ST_VBACK;
                else             state_next_s = ST_VSYNC;
            end
            ST_VBACK: begin
                if (phase_end_s) state_next_s = ST_ACTIVE;
                else             state_next_s = ST_VBACK;
            end
            ST_ACTIVE: begin
                if (phase_end_s) state_next_s = ST_VFRONT;
                else             state_next_s = ST_ACTIVE;
            end
            ST_VFRONT: begin
                if (phase_end_s && gen_en)  state_next_s = ST_VSYNC;
                else if (phase_end_s)       state_next_s = ST_IDLE;
                else                        state_next_s = ST_VFRONT;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register, pixel/line counters and per-frame pattern latch.
    always_ff @(posedge cmos_pclk) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            x_cnt_r    <= {XW{1'b0}};
            line_cnt_r <= {LW{1'b0}};
            pat_r      <= 2'd0;
            solid_r    <= 16'h0000;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_IDLE) begin
                x_cnt_r    <= {XW{1'b0}};
                line_cnt_r <= {LW{1'b0}};
            end else begin
                x_cnt_r <= line_end_s ? {XW{1'b0}} : x_cnt_r + XW'(1);
                if (phase_end_s)     line_cnt_r <= {LW{1'b0}};
                else if (line_end_s) line_cnt_r <= line_cnt_r + LW'(1);
                else                 line_cnt_r <= line_cnt_r;
            end
            if (frame_start_s) begin
                pat_r   <= pattern_sel;
                solid_r <= solid_color;
            end else begin
                pat_r   <= pat_r;
                solid_r <= solid_r;
            end
        end
    end

    assign bar_idx_s = 3'(x_cnt_r / X_BAR_W);
    assign x_low_s   = 6'(x_cnt_r);
    assign y_bit5_s  = 1'(line_cnt_r >> 5);

    // Pattern generator; x is x_cnt, y is the active line index.
    always_comb begin
        pat_pix_s = 16'h0000;
        case (pat_r)
            2'd0:    pat_pix_s = bar_color(bar_idx_s);
            2'd1:    pat_pix_s = {x_low_s[4:0], x_low_s, x_low_s[4:0]};
            2'd2:    pat_pix_s = solid_r;
            2'd3:    pat_pix_s = (x_low_s[5] ^ y_bit5_s) ? 16'hFFFF : 16'h0000;
            default: pat_pix_s = 16'h0000;
        endcase
    end

`ifdef CMOS_GEN_FRAME_TAG_EN
    assign pix_s = ((x_cnt_r == {XW{1'b0}}) && (line_cnt_r == {LW{1'b0}})) ? frame_cnt_r : pat_pix_s;
`else
    assign pix_s = pat_pix_s;
`endif

    // Registered stream outputs and frame bookkeeping.
    always_ff @(posedge cmos_pclk) begin
        if (sys_rst) begin
            vsync_r      <= 1'b0;
            href_r       <= 1'b0;
            data_r       <= 16'h0000;
            frame_done_r <= 1'b0;
            frame_cnt_r  <= 16'h0000;
        end else begin
            vsync_r      <= (state_r == ST_VSYNC);
            href_r       <= href_s;
            data_r       <= href_s ? pix_s : 16'h0000;
            frame_done_r <= frame_end_s;
            if (frame_end_s) frame_cnt_r <= frame_cnt_r + 16'd1;
            else             frame_cnt_r <= frame_cnt_r;
        end
    end

    assign cmos_vsync = vsync_r;
    assign cmos_href  = href_r;
    assign cmos_data  = data_r;
    assign frame_done = frame_done_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_cmos_stream_gen.sv
// Self-checking bench for cmos_stream_gen: frame-position reference model plus pinned literal checks.
module tb_cmos_stream_gen;

    localparam int HA = 16;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int L  = HA + HB;
    localparam int FRAME = (VS + VB + VA + VF) * L;
`ifdef CMOS_GEN_FRAME_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif
    localparam logic [15:0] BARS_LINE [16] = '{
        16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
        16'hF81F, 16'hF81F, 16'hF800, 16'hF800, 16'h001F, 16'h001F, 16'h0000, 16'h0000};

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        gen_en;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [15:0] cmos_data;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    cmos_stream_gen #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .cmos_pclk  (clk),
        .sys_rst    (sys_rst),
        .gen_en     (gen_en),
        .pattern_sel(pattern_sel),
        .solid_color(solid_color),
        .cmos_vsync (cmos_vsync),
        .cmos_href  (cmos_href),
        .cmos_data  (cmos_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int x, input int y, input logic [1:0] pat,
                                            input logic [15:0] sol, input logic [15:0] cnt);
        logic [15:0] xv;
        logic [15:0] yv;
        xv = 16'(x);
        yv = 16'(y);
        if (TAG_EN && x == 0 && y == 0) return cnt;
        case (pat)
            2'd0:    return BARS_LINE[(x / (HA / 8)) * 2];
            2'd1:    return {xv[4:0], xv[5:0], xv[4:0]};
            2'd2:    return sol;
            default: return (xv[5] ^ yv[5]) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Reference model: frame position of the outputs visible after each edge.
    logic        mdl_ok = 1'b0;
    logic        run_m  = 1'b0;
    int          pos_m  = 0;
    logic        done_m = 1'b0;
    logic [15:0] cnt_m  = 16'h0000;
    logic [1:0]  pat_m  = 2'd0;
    logic [15:0] sol_m  = 16'h0000;

    always @(posedge clk) begin
        if (sys_rst) begin
            mdl_ok <= 1'b1;
            run_m  <= 1'b0;
            pos_m  <= 0;
            done_m <= 1'b0;
            cnt_m  <= 16'h0000;
        end else if (run_m && pos_m == FRAME - 1) begin
            done_m <= 1'b1;
            cnt_m  <= cnt_m + 16'd1;
            pos_m  <= 0;
            run_m  <= gen_en;
            if (gen_en) begin
                pat_m <= pattern_sel;
                sol_m <= solid_color;
            end
        end else if (run_m) begin
            done_m <= 1'b0;
            pos_m  <= pos_m + 1;
        end else begin
            done_m <= 1'b0;
            pos_m  <= 0;
            run_m  <= gen_en;
            if (gen_en) begin
                pat_m <= pattern_sel;
                sol_m <= solid_color;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (mdl_ok) begin
            automatic logic        e_vs = 1'b0;
            automatic logic        e_hr = 1'b0;
            automatic logic [15:0] e_d  = 16'h0000;
            automatic int ln, col, y;
            if (run_m && pos_m >= 1) begin
                ln  = (pos_m - 1) / L;
                col = (pos_m - 1) % L;
                y   = ln - (VS + VB);
                e_vs = (ln < VS);
                e_hr = (y >= 0) && (y < VA) && (col < HA);
                if (e_hr) e_d = exp_pix(col, y, pat_m, sol_m, cnt_m);
            end
            chk("mdl_vsync", 16'(cmos_vsync), 16'(e_vs));
            chk("mdl_href",  16'(cmos_href),  16'(e_hr));
            chk("mdl_data",  cmos_data, e_d);
            chk("mdl_done",  16'(frame_done), 16'(done_m));
            chk("mdl_fcnt",  frame_cnt, cnt_m);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rises, hcyc;
        logic prev;
        sys_rst = 1'b1;
        gen_en = 1'b0;
        pattern_sel = 2'd0;
        solid_color = 16'h0000;
        repeat (3) step();
        chk("rst_vsync", 16'(cmos_vsync), 16'h0000);
        chk("rst_href",  16'(cmos_href),  16'h0000);
        chk("rst_data",  cmos_data, 16'h0000);
        chk("rst_done",  16'(frame_done), 16'h0000);
        chk("rst_fcnt",  frame_cnt, 16'h0000);
        sys_rst = 1'b0;
        step();
        chk("idle_vsync", 16'(cmos_vsync), 16'h0000);

        // Frame 0: colour bars, gen_en sampled at edge 0.
        gen_en = 1'b1;
        pattern_sel = 2'd0;
        step();
        chk("e0_vsync", 16'(cmos_vsync), 16'h0000);
        rises = 0; hcyc = 0; prev = 1'b0;
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (i == 1)  chk("f0_vsync_e1",  16'(cmos_vsync), 16'h0001);
            if (i == 20) chk("f0_vsync_e20", 16'(cmos_vsync), 16'h0001);
            if (i == 21) chk("f0_vsync_e21", 16'(cmos_vsync), 16'h0000);
            if (i == 40) chk("f0_href_e40",  16'(cmos_href),  16'h0000);
            if (i == 41) chk("f0_href_e41",  16'(cmos_href),  16'h0001);
            if (i == 41) chk("f0_pix0", cmos_data, TAG_EN ? 16'h0000 : 16'hFFFF);
            if (i > 41 && i <= 56) chk("f0_bars", cmos_data, BARS_LINE[i - 41]);
            if (i == 57) chk("f0_blank_data", cmos_data, 16'h0000);
            if (i == 139) chk("f0_done_e139", 16'(frame_done), 16'h0000);
            if (i == 140) chk("f0_done_e140", 16'(frame_done), 16'h0001);
            if (i == 140) chk("f0_fcnt", frame_cnt, 16'h0001);
            if (cmos_href && !prev) rises++;
            if (cmos_href) hcyc++;
            prev = cmos_href;
            if (i == 100) begin
                pattern_sel = 2'd2;
                solid_color = 16'h1234;
            end
        end
        chk("f0_href_rises", 16'(rises), 16'd4);
        chk("f0_href_cycles", 16'(hcyc), 16'd64);

        // Frame 1: solid 0x1234, colour changed mid-frame.
        for (int j = 1; j <= FRAME; j++) begin
            step();
            if (j == 41)  chk("f1_pix0", cmos_data, TAG_EN ? 16'h0001 : 16'h1234);
            if (j == 42)  chk("f1_pix1", cmos_data, 16'h1234);
            if (j == 60)  solid_color = 16'hABCD;
            if (j == 101) chk("f1_late_pix", cmos_data, 16'h1234);
        end

        // Frame 2: solid 0xABCD, gen_en dropped mid-frame.
        for (int j = 1; j <= FRAME + 10; j++) begin
            step();
            if (j == 41)  chk("f2_pix0", cmos_data, TAG_EN ? 16'h0002 : 16'hABCD);
            if (j == 42)  chk("f2_pix1", cmos_data, 16'hABCD);
            if (j == 60)  gen_en = 1'b0;
            if (j == 140) chk("f2_done", 16'(frame_done), 16'h0001);
            if (j == 140) chk("f2_fcnt", frame_cnt, 16'h0003);
            if (j == 145) chk("idle_after_vsync", 16'(cmos_vsync), 16'h0000);
            if (j == 150) chk("idle_fcnt", frame_cnt, 16'h0003);
        end

        // Reset mid-ACTIVE, then restart.
        gen_en = 1'b1;
        pattern_sel = 2'd1;
        step();
        repeat (70) step();
        chk("pre_rst_href", 16'(cmos_href), 16'h0001);
        sys_rst = 1'b1;
        step();
        chk("mid_rst_href", 16'(cmos_href), 16'h0000);
        chk("mid_rst_data", cmos_data, 16'h0000);
        chk("mid_rst_fcnt", frame_cnt, 16'h0000);
        sys_rst = 1'b0;
        step();
        chk("restart_e0_vsync", 16'(cmos_vsync), 16'h0000);
        step();
        chk("restart_e1_vsync", 16'(cmos_vsync), 16'h0001);

        // Randomized traffic checked by the model.
        for (int s = 0; s < 40; s++) begin
            gen_en      = ($urandom_range(3) != 0);
            pattern_sel = 2'($urandom_range(3));
            solid_color = 16'($urandom);
            if ($urandom_range(11) == 0) begin
                sys_rst = 1'b1;
                step();
                sys_rst = 1'b0;
            end
            repeat ($urandom_range(200, 1)) step();
        end
        gen_en = 1'b0;
        repeat (2 * FRAME) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
